cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Sequencing controller between the CPU load/store port, one cache set array, and the line-wide memory bus.
- Accepts one CPU request at a time and performs the lookup.
- On a miss, writes back a dirty victim line, refills the line from memory, installs it, then replays the original access.
- Returns read data or write completion through a valid/ready response.

Parameters:
- ADDR_W, 32, byte address width
- LINE_BITS, 128, cache line width (16 bytes)
- OFFSET_W, 4, line offset bits
- INDEX_W, 6, set index bits
- MEM_TIMEOUT, 1023, max cycles to wait for mem_ack before error

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- cpu_req_valid  in  1  CPU request present
- cpu_req_ready  out  1  controller can accept a request
- cpu_addr  in  32  byte address
- cpu_we  in  1  1=store, 0=load
- cpu_wdata  in  32  store data
- cpu_byte_en  in  2  01=byte, 10=half, other=word
- cpu_resp_valid  out  1  response pulse
- cpu_rdata  out  32  load data, valid with cpu_resp_valid
- cpu_err  out  1  memory timeout, valid with cpu_resp_valid
- arr_addr  out  32  address to array
- arr_wdata  out  32  store data to array
- arr_ldata  out  128  refill line to array
- arr_byte_en  out  2  size to array
- arr_read_en, arr_write_en, arr_load_en, arr_begin_load  out  1 each  array commands
- arr_hit  in  1  lookup hit
- arr_dirty  in  1  victim dirty
- arr_victim_tag  in  22  victim tag
- arr_rdata  in  32  array read data
- arr_wbdata  in  128  victim line
- arr_ready  in  1  array command complete
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1=line write, 0=line read
- mem_addr  out  32  line-aligned address, low 4 bits always 0
- mem_wdata  out  128  writeback line
- mem_rdata  in  128  refill line, valid with mem_ack
- mem_ack  in  1  single-cycle completion

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; all outputs 0 except cpu_req_ready=1; timeout counter=0.
  - Reset mid-transaction aborts it; mem_req drops the next cycle with no response.
- Request capture:
  - Accepted when cpu_req_valid && cpu_req_ready.
  - addr, we, wdata and byte_en are registered; cpu_req_ready=0 until the response cycle.
- States:
  - IDLE: on accept -> LOOKUP.
  - LOOKUP: drive arr_read_en (load) or arr_write_en (store) with the captured fields; wait for arr_ready.
    - Hit -> RESP; load data comes from arr_rdata.
    - Miss and arr_dirty -> WB; latch arr_wbdata and victim address {arr_victim_tag, index, 4'b0}.
    - Miss and not dirty -> REFILL.
  - WB: mem_req=1, mem_we=1, mem_wdata=latched line; on mem_ack -> REFILL.
  - REFILL: mem_req=1, mem_we=0, mem_addr={addr[31:4],4'b0}; on mem_ack latch mem_rdata -> INSTALL.
  - INSTALL: arr_load_en=1 until arr_ready, then one cycle arr_begin_load=1 with arr_ldata=latched line; -> REPLAY.
  - REPLAY: reissue the original access as in LOOKUP. A hit is required; a miss here sets cpu_err. -> RESP.
  - RESP: cpu_resp_valid=1 for exactly one cycle; cpu_req_ready=1 -> IDLE.
    - A new request may be accepted in this cycle; it goes directly to LOOKUP.
- Latency:
  - Load/store hit: response 2 cycles after accept when arr_ready returns in the same cycle.
  - Miss: adds memory latency plus 3 cycles; a dirty miss adds a second memory transaction.
- Timeout:
  - Counter runs while mem_req=1 and clears on mem_ack.
  - Reaching MEM_TIMEOUT -> RESP with cpu_err=1, cpu_rdata=0, array untouched.
- mem_ack received outside WB/REFILL is ignored.
- Array command outputs are mutually exclusive (one-hot or zero) every cycle.

Decomposition:
- Shared package cache_pkg:
  - line/offset/index/tag widths
  - byte_en encodings (BE_BYTE=2'b01, BE_HALF=2'b10, BE_WORD)
  - controller state enum
- Sub-module cache_mem_if: owns mem_req/mem_we/mem_addr/mem_wdata holding, mem_ack capture and the timeout counter. It presents a start/done/err handshake to the FSM.

Test Plan:
- Load hit: after a preloaded line at 0x0000_0040 containing 0xDEADBEEF at offset 0, load word 0x40 -> resp 2 cycles later, rdata=0xDEADBEEF, no mem_req.
- Clean miss: load byte 0x1234_5678 with mem returning a line whose byte 8 is 0xA5 -> one mem read at 0x1234_5670, then resp with rdata=0x000000A5.
- Dirty miss: store word 0x55AA55AA to 0x100 (hit), then load 0x500 at the same index -> mem write to 0x100 with that word at bits[31:0], then mem read at 0x500, in that order.
- Store miss: store half 0xBEEF to 0x2002 -> refill from 0x2000, replay; a subsequent load half at 0x2002 returns 0x0000BEEF.
- Timeout: no mem_ack for 1023 cycles -> resp with cpu_err=1, rdata=0, cpu_req_ready=1 next.
- Reset mid-REFILL: rst=0 while mem_req=1 -> next cycle mem_req=0, cpu_resp_valid=0, cpu_req_ready=1.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, size encodings and controller states for the cache controller.
// Load data returned to the CPU is masked to the requested access size.
package cache_pkg;

  localparam int ADDR_W    = 32;
  localparam int LINE_BITS = 128;
  localparam int WORD_W    = 32;
  localparam int OFFSET_W  = 4;
  localparam int INDEX_W   = 6;
  localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;

  localparam logic [1:0] BE_BYTE = 2'b01;
  localparam logic [1:0] BE_HALF = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_WB      = 3'd2,
    S_REFILL  = 3'd3,
    S_INSTALL = 3'd4,
    S_REPLAY  = 3'd5,
    S_RESP    = 3'd6
  } state_t;

  // Any encoding other than byte/half is treated as a full word.
  function automatic logic [WORD_W-1:0] be_mask(input logic [1:0] be);
    case (be)
      BE_BYTE: return 32'h0000_00FF;
      BE_HALF: return 32'h0000_FFFF;
      BE_WORD: return 32'hFFFF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/cache_mem_if.sv
// Holds one line-wide memory transaction from a start pulse until mem_ack or
// timeout, and reports completion to the controller FSM via done/err.
module cache_mem_if
  import cache_pkg::*;
#(
  parameter int MEM_TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 start_we,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic [LINE_BITS-1:0] start_wdata,
  output logic                 done,
  output logic                 err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic                 mem_ack
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // An ack that arrives while no request is outstanding is ignored.
  assign done = mem_req && mem_ack;
  assign err  = mem_req && !mem_ack && (cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
    end else if (start) begin
      mem_req   <= 1'b1;
      mem_we    <= start_we;
      mem_addr  <= start_addr;
      mem_wdata <= start_we ? start_wdata : '0;
      cnt       <= '0;
    end else if (done || err) begin
      mem_req <= 1'b0;
      cnt     <= '0;
    end else if (mem_req) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Cache sequencing controller: lookup, dirty writeback, refill, install and
// replay of a single outstanding CPU request.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int MEM_TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req_valid,
  output logic                 cpu_req_ready,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic                 cpu_we,
  input  logic [WORD_W-1:0]    cpu_wdata,
  input  logic [1:0]           cpu_byte_en,
  output logic                 cpu_resp_valid,
  output logic [WORD_W-1:0]    cpu_rdata,
  output logic                 cpu_err,
  output logic [ADDR_W-1:0]    arr_addr,
  output logic [WORD_W-1:0]    arr_wdata,
  output logic [LINE_BITS-1:0] arr_ldata,
  output logic [1:0]           arr_byte_en,
  output logic                 arr_read_en,
  output logic                 arr_write_en,
  output logic                 arr_load_en,
  output logic                 arr_begin_load,
  input  logic                 arr_hit,
  input  logic                 arr_dirty,
  input  logic [TAG_W-1:0]     arr_victim_tag,
  input  logic [WORD_W-1:0]    arr_rdata,
  input  logic [LINE_BITS-1:0] arr_wbdata,
  input  logic                 arr_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic [2:0]           dbg_state
);

  state_t               state;
  logic [ADDR_W-1:0]    q_addr;
  logic                 q_we;
  logic [WORD_W-1:0]    q_wdata;
  logic [1:0]           q_be;
  logic [LINE_BITS-1:0] q_line;
  logic                 mem_start, mem_start_we;
  logic [ADDR_W-1:0]    mem_start_addr;
  logic                 mem_done, mem_err;
  logic                 accept;

  // CPU handshake: a request transfers on any cycle where cpu_req_valid and
  // cpu_req_ready are both high; cpu_resp_valid is a one-cycle pulse that is
  // not back-pressured, and ready returns high in that same cycle.
  assign accept      = cpu_req_valid && cpu_req_ready;
  assign arr_addr    = q_addr;
  assign arr_wdata   = q_wdata;
  assign arr_byte_en = q_be;
  assign arr_ldata   = q_line;
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      cpu_req_ready  <= 1'b1;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
      cpu_err        <= 1'b0;
      arr_read_en    <= 1'b0;
      arr_write_en   <= 1'b0;
      arr_load_en    <= 1'b0;
      arr_begin_load <= 1'b0;
      q_addr         <= '0;
      q_we           <= 1'b0;
      q_wdata        <= '0;
      q_be           <= '0;
      q_line         <= '0;
      mem_start      <= 1'b0;
      mem_start_we   <= 1'b0;
      mem_start_addr <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      mem_start      <= 1'b0;
      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            q_addr        <= cpu_addr;
            q_we          <= cpu_we;
            q_wdata       <= cpu_wdata;
            q_be          <= cpu_byte_en;
            cpu_req_ready <= 1'b0;
            arr_read_en   <= !cpu_we;
            arr_write_en  <= cpu_we;
            state         <= S_LOOKUP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOOKUP, S_REPLAY: begin
          if (arr_ready) begin
            arr_read_en  <= 1'b0;
            arr_write_en <= 1'b0;
            if (arr_hit || state == S_REPLAY) begin
              // A miss on replay means the install did not take.
              cpu_resp_valid <= 1'b1;
              cpu_req_ready  <= 1'b1;
              cpu_err        <= !arr_hit;
              cpu_rdata      <= (arr_hit && !q_we) ? (arr_rdata & be_mask(q_be)) : '0;
              state          <= S_RESP;
            end else if (arr_dirty) begin
              q_line         <= arr_wbdata;
              mem_start      <= 1'b1;
              mem_start_we   <= 1'b1;
              mem_start_addr <= {arr_victim_tag, q_addr[OFFSET_W+INDEX_W-1:OFFSET_W],
                                 {OFFSET_W{1'b0}}};
              state          <= S_WB;
            end else begin
              mem_start      <= 1'b1;
              mem_start_we   <= 1'b0;
              mem_start_addr <= {q_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
              state          <= S_REFILL;
            end
          end
        end
        S_WB, S_REFILL: begin
          if (mem_err) begin
            cpu_resp_valid <= 1'b1;
            cpu_req_ready  <= 1'b1;
            cpu_err        <= 1'b1;
            cpu_rdata      <= '0;
            state          <= S_RESP;
          end else if (mem_done && state == S_WB) begin
            mem_start      <= 1'b1;
            mem_start_we   <= 1'b0;
            mem_start_addr <= {q_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            state          <= S_REFILL;
          end else if (mem_done) begin
            q_line      <= mem_rdata;
            arr_load_en <= 1'b1;
            state       <= S_INSTALL;
          end
        end
        S_INSTALL: begin
          // arr_begin_load doubles as the second phase of the install.
          if (arr_begin_load) begin
            arr_begin_load <= 1'b0;
            arr_read_en    <= !q_we;
            arr_write_en   <= q_we;
            state          <= S_REPLAY;
          end else if (arr_ready) begin
            arr_load_en    <= 1'b0;
            arr_begin_load <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  cache_mem_if #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_if (
    .clk        (clk),
    .rst        (rst),
    .start      (mem_start),
    .start_we   (mem_start_we),
    .start_addr (mem_start_addr),
    .start_wdata(q_line),
    .done       (mem_done),
    .err        (mem_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack)
  );

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural set array and line memory;
// responses and memory transactions are checked against expected queues.
module tb_cache_ctrl;
  import cache_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  logic         cpu_req_valid = 1'b0, cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
  logic [1:0]   cpu_byte_en = '0;
  logic         cpu_req_ready, cpu_resp_valid, cpu_err;
  logic [31:0]  cpu_rdata, arr_addr, arr_wdata, mem_addr;
  logic [127:0] arr_ldata, mem_wdata, arr_wbdata;
  logic [127:0] mem_rdata = '0;
  logic [1:0]   arr_byte_en;
  logic         arr_read_en, arr_write_en, arr_load_en, arr_begin_load;
  logic         arr_hit, arr_dirty, mem_req, mem_we, mem_ack;
  logic [21:0]  arr_victim_tag;
  logic [31:0]  arr_rdata;
  logic         arr_ready;
  logic [2:0]   dbg_state;

  cache_ctrl #(.MEM_TIMEOUT(1023)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_byte_en(cpu_byte_en),
    .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .arr_addr(arr_addr), .arr_wdata(arr_wdata), .arr_ldata(arr_ldata), .arr_byte_en(arr_byte_en),
    .arr_read_en(arr_read_en), .arr_write_en(arr_write_en),
    .arr_load_en(arr_load_en), .arr_begin_load(arr_begin_load),
    .arr_hit(arr_hit), .arr_dirty(arr_dirty), .arr_victim_tag(arr_victim_tag),
    .arr_rdata(arr_rdata), .arr_wbdata(arr_wbdata), .arr_ready(arr_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbg_state(dbg_state)
  );

  // scoreboard state
  int passed = 0, total = 0, fails = 0;
  logic [32:0] exp_q[$];      // {err, rdata}
  logic [32:0] exp_mem_q[$];  // {we, line address}
  int resp_cnt = 0, resp_cyc = 0, mem_txn_cnt = 0, mem_wait = 0, mem_lat = 1;
  bit mem_silent = 0, excl_viol = 0;
  logic model_ack = 1'b0, stray_ack = 1'b0;
  logic [127:0] mem_arr [bit [31:0]];
  assign mem_ack = model_ack | stray_ack;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return {a + 32'd3, a + 32'd2, a + 32'd1, a ^ 32'hA5A5_0000};
  endfunction

  function automatic logic [31:0] extract(input logic [127:0] l, input logic [3:0] off,
                                          input logic [1:0] be);
    int b;
    case (be)
      2'b01:   begin b = int'(off);               return {24'h0, l[b*8 +: 8]};  end
      2'b10:   begin b = int'({off[3:1], 1'b0});  return {16'h0, l[b*8 +: 16]}; end
      default: begin b = int'({off[3:2], 2'b00}); return l[b*8 +: 32];         end
    endcase
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] l, input logic [3:0] off,
                                         input logic [1:0] be, input logic [31:0] d);
    logic [127:0] r;
    int b;
    r = l;
    case (be)
      2'b01:   begin b = int'(off);               r[b*8 +: 8]  = d[7:0];  end
      2'b10:   begin b = int'({off[3:1], 1'b0});  r[b*8 +: 16] = d[15:0]; end
      default: begin b = int'({off[3:2], 2'b00}); r[b*8 +: 32] = d;       end
    endcase
    return r;
  endfunction

  // direct-mapped set array model
  logic         a_valid [64];
  logic         a_dirty [64];
  logic [21:0]  a_tag   [64];
  logic [127:0] a_data  [64];
  logic [5:0]   a_idx;
  bit           arr_init = 0;
  assign a_idx     = arr_addr[9:4];
  assign arr_ready = 1'b1;

  always_comb begin
    arr_hit        = a_valid[a_idx] && (a_tag[a_idx] == arr_addr[31:10]);
    arr_dirty      = a_valid[a_idx] && a_dirty[a_idx];
    arr_victim_tag = a_tag[a_idx];
    arr_wbdata     = a_data[a_idx];
    arr_rdata      = extract(a_data[a_idx], arr_addr[3:0], arr_byte_en);
  end

  always @(posedge clk) begin
    if (!arr_init) begin
      for (int i = 0; i < 64; i++) begin
        a_valid[i] <= 1'b0; a_dirty[i] <= 1'b0; a_tag[i] <= '0; a_data[i] <= '0;
      end
      a_valid[4]  <= 1'b1; a_data[4]  <= 128'hDEADBEEF;
      a_valid[16] <= 1'b1; a_data[16] <= 128'h44444444_33333333_22222222_11111111;
      arr_init <= 1;
    end else if (arr_write_en && arr_hit) begin
      a_data[a_idx]  <= merge(a_data[a_idx], arr_addr[3:0], arr_byte_en, arr_wdata);
      a_dirty[a_idx] <= 1'b1;
    end else if (arr_begin_load) begin
      a_data[a_idx]  <= arr_ldata;
      a_tag[a_idx]   <= arr_addr[31:10];
      a_valid[a_idx] <= 1'b1;
      a_dirty[a_idx] <= 1'b0;
    end
  end

  // memory model and transaction checker
  always @(negedge clk) begin
    logic [32:0] e;
    if (model_ack) model_ack = 1'b0;
    else if (rst && mem_req && !mem_silent) begin
      if (mem_wait >= mem_lat) begin
        mem_wait = 0;
        model_ack = 1'b1;
        mem_txn_cnt++;
        mem_rdata = mem_we ? '0 : mem_line(mem_addr);
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        chk("mem_addr_aligned", mem_addr[3:0], 4'h0);
        chk("mem_txn_expected", exp_mem_q.size() != 0, 1'b1);
        if (exp_mem_q.size() != 0) begin
          e = exp_mem_q.pop_front();
          chk("mem_we", mem_we, e[32]);
          chk("mem_addr", mem_addr, e[31:0]);
        end
      end else mem_wait++;
    end else mem_wait = 0;
  end

  // response monitor
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst && $countones({arr_read_en, arr_write_en, arr_load_en, arr_begin_load}) > 1)
      excl_viol = 1;
    if (rst && cpu_resp_valid) begin
      resp_cnt++;
      resp_cyc = int'(cyc);
      chk("resp_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("resp_rdata", cpu_rdata, e[31:0]);
        chk("resp_err", cpu_err, e[32]);
      end
    end
  end

  // driver: one request, wait for its response, return accept-to-response latency
  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [1:0] be, input logic [31:0] exp_rd, input logic exp_err,
                      output int lat);
    int n, acc, guard;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_addr = a; cpu_we = w; cpu_wdata = d; cpu_byte_en = be;
    exp_q.push_back({exp_err, exp_rd});
    n = resp_cnt;
    guard = 0;
    while (!cpu_req_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("req_ready", cpu_req_ready, 1'b1);
    acc = int'(cyc);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    chk("ready_low_busy", cpu_req_ready, 1'b0);
    guard = 0;
    while (resp_cnt == n && guard < 3000) begin @(negedge clk); guard++; end
    chk("resp_arrived", resp_cnt != n, 1'b1);
    lat = resp_cyc - acc;
    @(negedge clk);
    chk("resp_one_cycle", cpu_resp_valid, 1'b0);
    chk("ready_after_resp", cpu_req_ready, 1'b1);
  endtask

  initial begin
    int lat, guard, n;
    logic [127:0] line_v, pat;
    logic [31:0] a;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", cpu_req_ready, 1'b1);
    chk("rst_resp", cpu_resp_valid, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_arr_cmds", {arr_read_en, arr_write_en, arr_load_en, arr_begin_load}, 4'b0);
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_err_rdata", {cpu_err, cpu_rdata}, 33'h0);
    rst = 1'b1;

    // load hit
    n = mem_txn_cnt;
    send(32'h40, 1'b0, 32'h0, BE_WORD, 32'hDEADBEEF, 1'b0, lat);
    chk("hit_latency", lat, 2);
    chk("hit_no_mem", mem_txn_cnt, n);

    // clean load-byte miss
    a = 32'h1234_5678;
    line_v = {$urandom, $urandom, $urandom, $urandom};
    line_v[71:64] = 8'hA5;
    mem_arr[32'h1234_5670] = line_v;
    mem_lat = $urandom_range(1, 5);
    exp_mem_q.push_back({1'b0, 32'h1234_5670});
    send(a, 1'b0, 32'h0, BE_BYTE, 32'h0000_00A5, 1'b0, lat);
    chk("clean_miss_installed", a_data[a[9:4]], line_v);

    // store hit then dirty miss on the same index
    send(32'h100, 1'b1, 32'h55AA_55AA, BE_WORD, 32'h0, 1'b0, lat);
    chk("store_hit_latency", lat, 2);
    chk("store_hit_dirty", a_dirty[16], 1'b1);
    pat = mem_line(32'h500);
    mem_lat = $urandom_range(1, 5);
    exp_mem_q.push_back({1'b1, 32'h100});
    exp_mem_q.push_back({1'b0, 32'h500});
    send(32'h500, 1'b0, 32'h0, BE_WORD, pat[31:0], 1'b0, lat);
    chk("wb_line", mem_arr.exists(32'h100) ? mem_arr[32'h100] : 128'h0,
        128'h44444444_33333333_22222222_55AA55AA);

    // store-half miss, then read it back as a hit
    exp_mem_q.push_back({1'b0, 32'h2000});
    send(32'h2002, 1'b1, 32'h1234_BEEF, BE_HALF, 32'h0, 1'b0, lat);
    send(32'h2002, 1'b0, 32'h0, BE_HALF, 32'h0000_BEEF, 1'b0, lat);
    chk("store_miss_readback_latency", lat, 2);

    // stray ack while idle
    n = resp_cnt;
    @(negedge clk); stray_ack = 1'b1;
    @(negedge clk); stray_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_state", dbg_state, S_IDLE);
    chk("stray_ack_no_resp", resp_cnt, n);

    // memory timeout
    mem_silent = 1;
    send(32'h3450, 1'b0, 32'h0, BE_WORD, 32'h0, 1'b1, lat);
    chk("timeout_latency", (lat >= 1023) && (lat <= 1030), 1'b1);
    chk("timeout_mem_req_drop", mem_req, 1'b0);
    chk("timeout_array_untouched", a_valid[5], 1'b0);

    // reset while waiting on refill
    n = resp_cnt;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_addr = 32'h4060; cpu_we = 1'b0; cpu_byte_en = BE_WORD;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    guard = 0;
    while (!mem_req && guard < 20) begin @(negedge clk); guard++; end
    chk("refill_req_seen", mem_req, 1'b1);
    chk("refill_state", dbg_state, S_REFILL);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_resp", cpu_resp_valid, 1'b0);
    chk("rst_mid_ready", cpu_req_ready, 1'b1);
    rst = 1'b1;
    mem_silent = 0;
    @(negedge clk);
    chk("rst_mid_no_resp", resp_cnt, n);

    // recovery
    send(32'h40, 1'b0, 32'h0, BE_WORD, 32'hDEADBEEF, 1'b0, lat);
    chk("recover_latency", lat, 2);

    chk("arr_cmd_exclusive", excl_viol, 1'b0);
    chk("resp_queue_drained", exp_q.size(), 0);
    chk("mem_queue_drained", exp_mem_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
